// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: datapath width,
// the NOP encoding used for IF/ID bubbles, and the fetch-stage state type.
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance reporting; sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count qualified events, holding once every bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, talks to a
// variable-latency instruction memory, parks an instruction that returns while
// the pipeline is stalled, and counts stall / flush cycles.
module if_fetch_stage #(
    parameter int unsigned      XLEN     = pipe_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             flush,
    input  logic [XLEN-1:0]  branch_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      if_id_instr,
    output logic [XLEN-1:0]  if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    import pipe_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [31:0]     buf_q, buf_d;

    logic            advance;
    logic [XLEN-1:0] pc_plus4;

    assign advance  = pc_write & if_id_write;
    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state decode: flush beats stall, stall beats normal advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        case (state_q)
            FETCH: begin
                if (flush) begin
                    // Redirect; whatever memory returns this cycle is wrong-path.
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (imem_ready) begin
                    if (advance) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        // Memory answered during a stall: keep the word, stop requesting.
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (if_id_write) begin
                    // Nothing arrived but ID is consuming: hand it a bubble.
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (advance) begin
                    instr_d = buf_q;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Control state, PC and IF/ID register; reset discards any pending fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Holding buffer is pure data; it is only read after being written in FETCH.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Request is suppressed while reset is asserted so it rises on the first free cycle.
    assign imem_req    = (state_q == FETCH) & ~reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~if_id_write),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, pc_write, if_id_write, flush, imem_ready;
    logic [31:0]      branch_target, imem_rdata;
    logic             imem_req, if_id_valid;
    logic [31:0]      imem_addr, pc, if_id_instr, if_id_pc4;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the fetch PC, the IF/ID contents, and an optional parked instruction.
    logic [31:0] m_pc, m_instr, m_pc4, m_buf;
    bit          m_valid, m_parked, model_live;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    if_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; memory returns 0x1000_0000 | address.
    task automatic drive(input bit r, input bit pw, input bit iw, input bit fl,
                         input logic [31:0] tgt, input bit rdy);
        reset         = r;
        pc_write      = pw;
        if_id_write   = iw;
        flush         = fl;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = rdy ? (32'h1000_0000 | m_pc) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic check_all();
        chk("imem_req",     {31'd0, imem_req}, {31'd0, (!reset && !m_parked)});
        chk("imem_addr",    imem_addr, m_pc);
        chk("pc",           pc, m_pc);
        chk("if_id_instr",  if_id_instr, m_instr);
        chk("if_id_pc4",    if_id_pc4, m_pc4);
        chk("if_id_valid",  {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("stall_cycles", 32'(stall_cycles), m_stall);
        chk("flush_count",  32'(flush_count), m_flush);
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // An instruction is available to ID if one is parked or memory answers now;
    // it moves into IF/ID only when both stall requests are released.
    task automatic model_update();
        bit adv;
        adv = pc_write && if_id_write;
        if (reset) begin
            m_pc = RESET_PC; bubble(); m_parked = 0;
            m_stall = 0; m_flush = 0; model_live = 1;
        end else begin
            if (!if_id_write && m_stall < CMAX) m_stall++;
            if (flush && m_flush < CMAX) m_flush++;
            if (flush) begin
                m_pc = branch_target; bubble(); m_parked = 0;
            end else if (adv && (m_parked || imem_ready)) begin
                m_instr  = m_parked ? m_buf : imem_rdata;
                m_pc     = m_pc + 32'd4;
                m_pc4    = m_pc;
                m_valid  = 1'b1;
                m_parked = 0;
            end else if (!m_parked && imem_ready) begin
                m_parked = 1;
                m_buf    = imem_rdata;
            end else if (!m_parked && if_id_write) begin
                bubble();
            end
        end
    endtask

    task automatic step();
        if (model_live) check_all();
        model_update();
        @(negedge clk);
    endtask

    initial begin
        bit          r, pw, iw, fl, rdy;
        logic [31:0] tgt;
        model_live = 0;
        m_parked   = 0;
        m_pc       = RESET_PC;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 32'h0, 0);
            step();
        end
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);

        // First free cycle requests RESET_PC; zero-wait stream.
        drive(0, 1, 1, 0, 32'h0, 1);
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        step();
        chk("s0_pc4",   if_id_pc4, 32'd4);
        chk("s0_instr", if_id_instr, 32'h1000_0000);
        drive(0, 1, 1, 0, 32'h0, 1);
        step();
        chk("s1_pc4",   if_id_pc4, 32'd8);
        chk("s1_instr", if_id_instr, 32'h1000_0004);
        chk("s1_valid", {31'd0, if_id_valid}, 32'd1);

        // Memory answers at pc=8 during a one-cycle stall.
        drive(0, 0, 0, 0, 32'h0, 1);
        step();
        chk("hold_req",   {31'd0, imem_req}, 32'd0);
        chk("hold_pc4",   if_id_pc4, 32'd8);
        chk("hold_stall", 32'(stall_cycles), 32'd1);
        drive(0, 1, 1, 0, 32'h0, 0);
        step();
        chk("unhold_instr", if_id_instr, 32'h1000_0008);
        chk("unhold_pc",    pc, 32'd12);
        chk("unhold_pc4",   if_id_pc4, 32'd12);

        // Flush while memory is waiting.
        drive(0, 1, 1, 1, 32'h40, 0);
        step();
        chk("fl_pc",    pc, 32'h40);
        chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
        chk("fl_cnt",   32'(flush_count), 32'd1);
        drive(0, 1, 1, 0, 32'h0, 1);
        step();
        chk("fl_instr", if_id_instr, 32'h1000_0040);

        // Flush out of HOLD with if_id_write low drops the parked word.
        drive(0, 0, 0, 0, 32'h0, 1);
        step();
        drive(0, 0, 0, 1, 32'h80, 0);
        step();
        chk("hfl_valid", {31'd0, if_id_valid}, 32'd0);
        chk("hfl_pc",    pc, 32'h80);
        drive(0, 1, 1, 0, 32'h0, 1);
        chk("hfl_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("hfl_instr", if_id_instr, 32'h1000_0080);

        // Long stall saturates the counter.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 32'h0, 0);
            step();
        end
        chk("sat_stall", 32'(stall_cycles), 32'd15);

        // PC wraps past the top of the address space.
        drive(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
        step();
        drive(0, 1, 1, 0, 32'h0, 1);
        step();
        chk("wrap_pc",    pc, 32'h0);
        chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC);

        // Reset while parked in HOLD.
        drive(0, 0, 0, 0, 32'h0, 1);
        step();
        drive(1, 1, 1, 0, 32'h0, 0);
        step();
        chk("rh_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rh_stall", 32'(stall_cycles), 32'd0);
        drive(0, 1, 1, 0, 32'h0, 0);
        chk("rh_req", {31'd0, imem_req}, 32'd1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 3) != 0);
            rdy = !r && !m_parked && ($urandom_range(0, 1) == 1);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            drive(r, pw, iw, fl, tgt, rdy);
            step();
        end
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
